// File: rtl/operand_shifter.sv
// Operand B builder for ARM7 data-processing instructions: rotated immediates,
// immediate shifts and register-specified shifts, with the shifter carry-out.
// Operand A is passed through so both operands reach the ALU together.
module operand_shifter #(
  parameter bit REG_SHIFT_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  input  logic [31:0] rs_data,
  input  logic        is_imm,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic        shift_by_reg,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_carry
);

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state;
  logic [31:0] cap_a;
  logic [31:0] cap_rm;
  logic [7:0]  cap_amt;
  logic [1:0]  cap_type;
  logic        cap_c;

  logic        transfer;
  logic        take_stall;
  logic [32:0] live_res;
  logic [32:0] cap_res;
  logic        unused_rs;

  // Rotate a word right by 0..31.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] t;
    t = {v, v} >> r;
    return t[31:0];
  endfunction

  // imm8 ROR 2*rot4; carry only changes when a rotation actually happens.
  function automatic logic [32:0] rot_imm(input logic [7:0] imm, input logic [3:0] rot,
                                          input logic c);
    logic [31:0] b;
    b = ror32({24'd0, imm}, {rot, 1'b0});
    return {(rot == 4'd0) ? c : b[31], b};
  endfunction

  // Register-style shift by a full 8-bit amount; result is {carry, value}.
  // The extra bit below/above the word catches the last bit shifted out.
  function automatic logic [32:0] shift_core(input logic [31:0] rm, input logic [7:0] amt,
                                             input logic [1:0] st, input logic c);
    logic [32:0] r;
    logic [31:0] b;
    logic [32:0] res;
    res = {c, rm};
    if (amt != 8'd0) begin
      case (st)
        SH_LSL: res = {1'b0, rm} << amt;
        SH_LSR: begin
          r   = {rm, 1'b0} >> amt;
          res = {r[0], r[32:1]};
        end
        SH_ASR: begin
          r   = $signed({rm, 1'b0}) >>> amt;
          res = {r[0], r[32:1]};
        end
        default: begin
          if (amt[4:0] == 5'd0) begin
            res = {rm[31], rm};
          end else begin
            b   = ror32(rm, amt[4:0]);
            res = {b[31], b};
          end
        end
      endcase
    end
    return res;
  endfunction

  // Immediate shift: amount 0 encodes LSL #0, LSR/ASR #32 or RRX.
  function automatic logic [32:0] shift_imm_op(input logic [31:0] rm, input logic [4:0] n,
                                               input logic [1:0] st, input logic c);
    logic [32:0] res;
    if (n != 5'd0) begin
      res = shift_core(rm, {3'd0, n}, st, c);
    end else begin
      case (st)
        SH_LSL:  res = {c, rm};
        SH_LSR,
        SH_ASR:  res = shift_core(rm, 8'd32, st, c);
        default: res = {rm[0], c, rm[31:1]};
      endcase
    end
    return res;
  endfunction

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign transfer   = in_valid && in_ready;
  assign take_stall = REG_SHIFT_STALL && shift_by_reg && !is_imm;
  assign unused_rs  = ^rs_data[31:8];

  // Single-cycle result computed from the live decode inputs.
  always_comb begin
    live_res = {c_in, rm_data};
    if (is_imm) begin
      live_res = rot_imm(imm8, rot4, c_in);
    end else if (shift_by_reg) begin
      live_res = shift_core(rm_data, rs_data[7:0], shift_type, c_in);
    end else begin
      live_res = shift_imm_op(rm_data, shift_imm, shift_type, c_in);
    end
  end

  // Register-shift result from operands captured on acceptance.
  always_comb begin
    cap_res = shift_core(cap_rm, cap_amt, cap_type, cap_c);
  end

  // Control FSM, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_a     <= 32'd0;
      out_b     <= 32'd0;
      out_carry <= 1'b0;
      cap_a     <= 32'd0;
      cap_rm    <= 32'd0;
      cap_amt   <= 8'd0;
      cap_type  <= 2'd0;
      cap_c     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            if (take_stall) begin
              cap_a     <= rn_data;
              cap_rm    <= rm_data;
              cap_amt   <= rs_data[7:0];
              cap_type  <= shift_type;
              cap_c     <= c_in;
              state     <= SHIFT;
              out_valid <= 1'b0;
            end else begin
              out_a                <= rn_data;
              {out_carry, out_b}   <= live_res;
              out_valid            <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          out_a              <= cap_a;
          {out_carry, out_b} <= cap_res;
          out_valid          <= 1'b1;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule
